writeback_stage: RTL

Memory/writeback boundary stage of the five-stage core and sole driver of the register file write port. It accepts one retiring instruction per cycle from the memory stage and waits for variable-latency load responses. It formats load data (byte/half/word, signed/unsigned) and issues one registered write per instruction on `reg_wrMW`/`waddr_MW`/`wdata`.

---
 rtl/writeback_stage.sv | 102 ++++++++++
 1 files changed

// File: rtl/writeback_stage.sv
// Memory/writeback boundary: accepts one retiring instruction per cycle, waits for
// load responses, formats load data and drives the single register file write port.
module writeback_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            mem_valid,
   output logic            mem_ready,
   input  logic            mem_reg_wr,
   input  logic [4:0]      mem_rd,
   input  logic [XLEN-1:0] mem_result,
   input  logic            mem_is_load,
   input  logic [2:0]      mem_load_type,
   input  logic [1:0]      mem_addr_lo,
   input  logic            lsu_rvalid,
   input  logic [XLEN-1:0] lsu_rdata,
   output logic            reg_wrMW,
   output logic [4:0]      waddr_MW,
   output logic [XLEN-1:0] wdata,
   output logic            stall_load,
   output logic            unexp_rsp
);

   // Handshake: an instruction moves from the memory stage when mem_valid && mem_ready
   // on a rising edge; mem_ready is low for the whole time a load response is pending.
   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   state_t      state;
   logic [4:0]  ld_rd;
   logic        ld_reg_wr;
   logic [2:0]  ld_type;
   logic [1:0]  ld_addr_lo;
   logic [XLEN-1:0] load_data;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign mem_ready  = (state == IDLE);
   assign stall_load = (state == WAIT);

   // Pick the addressed byte/half out of the aligned word, then extend by funct3.
   always_comb begin
      byte_sel  = lsu_rdata[8*ld_addr_lo +: 8];
      half_sel  = lsu_rdata[16*ld_addr_lo[1] +: 16];
      load_data = lsu_rdata;
      case (ld_type)
         3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
         3'b100:  load_data = {24'd0, byte_sel};
         3'b101:  load_data = {16'd0, half_sel};
         default: load_data = lsu_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         reg_wrMW   <= 1'b0;
         waddr_MW   <= 5'd0;
         wdata      <= '0;
         unexp_rsp  <= 1'b0;
         ld_rd      <= 5'd0;
         ld_reg_wr  <= 1'b0;
         ld_type    <= 3'd0;
         ld_addr_lo <= 2'd0;
      end else begin
         reg_wrMW  <= 1'b0;
         unexp_rsp <= 1'b0;
         case (state)
            IDLE: begin
               // A response with nothing outstanding is dropped and flagged.
               unexp_rsp <= lsu_rvalid;
               if (mem_valid) begin
                  if (mem_is_load) begin
                     ld_rd      <= mem_rd;
                     ld_reg_wr  <= mem_reg_wr;
                     ld_type    <= mem_load_type;
                     ld_addr_lo <= mem_addr_lo;
                     state      <= WAIT;
                  end else if (mem_reg_wr && (mem_rd != 5'd0)) begin
                     reg_wrMW <= 1'b1;
                     waddr_MW <= mem_rd;
                     wdata    <= mem_result;
                  end
               end
            end
            WAIT: begin
               if (lsu_rvalid) begin
                  if (ld_reg_wr && (ld_rd != 5'd0)) begin
                     reg_wrMW <= 1'b1;
                     waddr_MW <= ld_rd;
                     wdata    <= load_data;
                  end
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
